// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron layer: reset-mode encoding and
// width-generic saturating-add / popcount helpers.
package lif_pkg;

    typedef enum logic {
        RST_ZERO = 1'b0,
        RST_SUB  = 1'b1
    } reset_mode_e;

    // Helpers operate on a fixed carrier width; callers pass their real width.
    localparam int unsigned MAX_W = 32;

    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned      w);
        logic [MAX_W:0] sum;
        logic [MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/lif_if.sv
// Step/result bundle between the current source and a lif_layer.
interface lif_if #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic [N_CH*WIDTH-1:0]   current;
    logic [WIDTH-1:0]        threshold;
    logic                    reset_mode;
    logic [N_CH-1:0]         spike;
    logic [N_CH*WIDTH-1:0]   state;
    logic                    out_valid;
    logic [CNT_W-1:0]        spike_count;

    modport master (
        output in_valid, current, threshold, reset_mode,
        input  spike, state, out_valid, spike_count
    );

    modport slave (
        input  in_valid, current, threshold, reset_mode,
        output spike, state, out_valid, spike_count
    );
endinterface

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter,
// shift leak, saturating integration and fire/reset logic.
module lif_cell
    import lif_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] threshold,
    input  logic             reset_mode,
    output logic             fire,
    output logic             spike,
    output logic [WIDTH-1:0] state
);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [RW-1:0]    ref_cnt;
    logic             ready;
    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] nxt;

    // state - (state >> k) never underflows, so only the add needs saturation.
    always_comb begin
        ready  = (ref_cnt == '0);
        leaked = state - (state >> LEAK_SHIFT);
        inc    = ready ? current : '0;
        nxt    = WIDTH'(sat_add(MAX_W'(leaked), MAX_W'(inc), WIDTH));
        fire   = ready && (nxt >= threshold);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= '0;
            ref_cnt <= '0;
            spike   <= 1'b0;
        end else begin
            spike <= step && fire;
            if (step) begin
                if (fire) begin
                    state   <= (reset_mode == RST_SUB) ? nxt - threshold : '0;
                    ref_cnt <= RW'(REFRAC);
                end else begin
                    state <= nxt;
                    if (!ready) ref_cnt <= ref_cnt - RW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/lif_layer.sv
// N_CH independent LIF neurons sharing a step strobe, threshold and reset mode,
// plus a one-cycle out_valid and a saturating aggregate spike counter.
module lif_layer
    import lif_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2,
    parameter int CNT_W      = 16
) (
    input logic  clk,
    input logic  rst,
    lif_if.slave bus
);
    logic [N_CH-1:0]       fire_vec;
    logic [N_CH-1:0]       spike_vec;
    logic [N_CH*WIDTH-1:0] state_vec;
    logic                  out_valid;
    logic [CNT_W-1:0]      spike_count;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        lif_cell #(
            .WIDTH      (WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REFRAC     (REFRAC)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .step       (bus.in_valid),
            .current    (bus.current[k*WIDTH +: WIDTH]),
            .threshold  (bus.threshold),
            .reset_mode (bus.reset_mode),
            .fire       (fire_vec[k]),
            .spike      (spike_vec[k]),
            .state      (state_vec[k*WIDTH +: WIDTH])
        );
    end

    // Counter is fed by this step's fire decisions so it updates together
    // with the spike outputs it accounts for.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            spike_count <= '0;
        end else begin
            out_valid <= bus.in_valid;
            if (bus.in_valid)
                spike_count <= CNT_W'(sat_add(MAX_W'(spike_count),
                                              MAX_W'(popcount(MAX_W'(fire_vec))),
                                              CNT_W));
        end
    end

    assign bus.spike       = spike_vec;
    assign bus.state       = state_vec;
    assign bus.out_valid   = out_valid;
    assign bus.spike_count = spike_count;

endmodule

// File: tb/tb_lif_layer.sv
// Directed plus randomized bench for lif_layer against an arithmetic model;
// a second instance with a 3-bit counter exercises counter saturation.
module tb_lif_layer;
    localparam int N_CH   = 4;
    localparam int WIDTH  = 8;
    localparam int LS     = 1;
    localparam int REFRAC = 2;
    localparam int SMAX   = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                  in_valid   = 1'b0;
    logic [N_CH*WIDTH-1:0] current    = '0;
    logic [WIDTH-1:0]      threshold  = '0;
    logic                  reset_mode = 1'b0;

    lif_if #(.N_CH(N_CH), .WIDTH(WIDTH), .CNT_W(16)) bus_a ();
    lif_if #(.N_CH(N_CH), .WIDTH(WIDTH), .CNT_W(3))  bus_b ();

    assign bus_a.in_valid   = in_valid;
    assign bus_a.current    = current;
    assign bus_a.threshold  = threshold;
    assign bus_a.reset_mode = reset_mode;
    assign bus_b.in_valid   = in_valid;
    assign bus_b.current    = current;
    assign bus_b.threshold  = threshold;
    assign bus_b.reset_mode = reset_mode;

    lif_layer #(.N_CH(N_CH), .WIDTH(WIDTH), .LEAK_SHIFT(LS), .REFRAC(REFRAC), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    lif_layer #(.N_CH(N_CH), .WIDTH(WIDTH), .LEAK_SHIFT(LS), .REFRAC(REFRAC), .CNT_W(3))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int checks = 0;
    int errors = 0;

    // Reference model
    int              m_state [N_CH];
    int              m_ref   [N_CH];
    logic [N_CH-1:0] m_spike;
    logic            m_valid;
    int              m_cnt_a;
    int              m_cnt_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int fired, s, nxt, inc, thr;
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                m_state[k] = 0;
                m_ref[k]   = 0;
            end
            m_spike = '0;
            m_valid = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (in_valid) begin
            fired = 0;
            thr   = int'(threshold);
            for (int k = 0; k < N_CH; k++) begin
                s   = m_state[k];
                inc = (m_ref[k] == 0) ? int'(current[k*WIDTH +: WIDTH]) : 0;
                nxt = s - (s >> LS) + inc;
                if (nxt > SMAX) nxt = SMAX;
                if (m_ref[k] == 0 && nxt >= thr) begin
                    m_spike[k] = 1'b1;
                    m_state[k] = reset_mode ? nxt - thr : 0;
                    m_ref[k]   = REFRAC;
                    fired++;
                end else begin
                    m_spike[k] = 1'b0;
                    m_state[k] = nxt;
                    if (m_ref[k] > 0) m_ref[k]--;
                end
            end
            m_cnt_a = (m_cnt_a + fired > 65535) ? 65535 : m_cnt_a + fired;
            m_cnt_b = (m_cnt_b + fired > 7) ? 7 : m_cnt_b + fired;
            m_valid = 1'b1;
        end else begin
            m_spike = '0;
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < N_CH; k++)
            check($sformatf("%s_state%0d", tag, k),
                  64'(bus_a.state[k*WIDTH +: WIDTH]), 64'(m_state[k]));
        check({tag, "_spike"},     64'(bus_a.spike),       64'(m_spike));
        check({tag, "_out_valid"}, 64'(bus_a.out_valid),   64'(m_valid));
        check({tag, "_count"},     64'(bus_a.spike_count), 64'(m_cnt_a));
        check({tag, "_count3"},    64'(bus_b.spike_count), 64'(m_cnt_b));
        check({tag, "_b_spike"},   64'(bus_b.spike),       64'(m_spike));
    endtask

    // One clock edge with the currently driven inputs, then compare at edge+1.
    task automatic tick(input string tag, input logic v);
        in_valid = v;
        @(posedge clk);
        model_update();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick(tag, 1'b1);
        rst = 1'b0;
    endtask

    task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
        current = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
    endtask

    initial begin
        // Reset state
        set_cur(0, 0, 0, 0);
        tick("por", 1'b0);
        rst = 1'b0;

        // 1: reset-to-zero with refractory period
        reset_mode = 1'b0; threshold = 8'd150; set_cur(100, 0, 0, 0);
        tick("t1_s1", 1'b1);
        check("t1_s1_lit", 64'(bus_a.state[7:0]), 64'd100);
        tick("t1_s2", 1'b1);
        check("t1_s2_spk", 64'(bus_a.spike[0]), 64'd1);
        check("t1_s2_lit", 64'(bus_a.state[7:0]), 64'd0);
        tick("t1_s3", 1'b1);
        tick("t1_s4", 1'b1);
        check("t1_s4_lit", 64'(bus_a.state[7:0]), 64'd0);
        tick("t1_s5", 1'b1);
        check("t1_s5_lit", 64'(bus_a.state[7:0]), 64'd100);
        check("t1_s5_cnt", 64'(bus_a.spike_count), 64'd1);

        // 2: reset-by-subtraction
        do_reset("t2_rst");
        reset_mode = 1'b1; threshold = 8'd150; set_cur(120, 0, 0, 0);
        tick("t2_s1", 1'b1);
        check("t2_s1_lit", 64'(bus_a.state[7:0]), 64'd120);
        tick("t2_s2", 1'b1);
        check("t2_s2_lit", 64'(bus_a.state[7:0]), 64'd30);
        check("t2_s2_spk", 64'(bus_a.spike[0]), 64'd1);

        // 3: asymptote; floor leak makes the fixed point 200, so 201 is never reached
        do_reset("t3_rst");
        reset_mode = 1'b0; threshold = 8'd201; set_cur(100, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick("t3", 1'b1);
            check("t3_nospk", 64'(bus_a.spike), 64'd0);
        end
        check("t3_final", 64'(bus_a.state[7:0]), 64'd200);

        // 4: saturation coinciding with fire, then threshold 0
        do_reset("t4_rst");
        reset_mode = 1'b1; threshold = 8'd255; set_cur(200, 0, 0, 0);
        tick("t4_s1", 1'b1);
        tick("t4_s2", 1'b1);
        check("t4_sat_spk", 64'(bus_a.spike[0]), 64'd1);
        check("t4_sat_st",  64'(bus_a.state[7:0]), 64'd0);
        threshold = 8'd0; set_cur(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick("t4_thr0", 1'b1);

        // 5: gaps and reset during a step
        reset_mode = 1'b0; threshold = 8'd250; set_cur(40, 80, 120, 160);
        tick("t5_step", 1'b1);
        set_cur(255, 255, 255, 255);
        for (int i = 0; i < 3; i++) tick("t5_gap", 1'b0);
        tick("t5_after", 1'b1);
        rst = 1'b1;
        tick("t5_rst", 1'b1);
        check("t5_rst_ov", 64'(bus_a.out_valid), 64'd0);
        rst = 1'b0;

        // 6: simultaneous volleys and counter saturation
        reset_mode = 1'b0; threshold = 8'd10; set_cur(50, 50, 50, 50);
        tick("t6_v1", 1'b1);
        check("t6_v1_spk", 64'(bus_a.spike), 64'hF);
        check("t6_v1_cnt", 64'(bus_b.spike_count), 64'd4);
        tick("t6_ref1", 1'b1);
        tick("t6_ref2", 1'b1);
        tick("t6_v2", 1'b1);
        check("t6_v2_cnt3", 64'(bus_b.spike_count), 64'd7);
        check("t6_v2_cnt",  64'(bus_a.spike_count), 64'd8);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            current    = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            threshold  = 8'($urandom);
            reset_mode = 1'($urandom);
            rst        = ($urandom_range(0, 49) == 0);
            tick("rnd", ($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
